debug_step_ctrl: RTL and testbench

DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

---
 rtl/debug_step_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_debug_step_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_step_ctrl.sv
// Run/step/breakpoint controller that gates a CPU clock enable from a debounced run switch and
// step key, with a fetch-address breakpoint and a saturating count of enabled cycles.
module debug_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ADDR_W          = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              run_sw,
    input  logic              step_key_n,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [ADDR_W-1:0] instr_if,
    output logic              cpu_en,
    output logic              halted,
    output logic              bp_hit,
    output logic [15:0]       step_count
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned NumCh = 2;
    localparam int unsigned ChRun = 0;
    localparam int unsigned ChKey = 1;
    // Inactive levels: run switch low, step key released (high).
    localparam logic [NumCh-1:0] InIdle = 2'b10;

    typedef enum logic [1:0] {
        StHalt  = 2'd0,
        StStep  = 2'd1,
        StRun   = 2'd2,
        StBreak = 2'd3
    } state_e;

    logic [NumCh-1:0]           raw_in;
    logic [NumCh-1:0]           sync1_q;
    logic [NumCh-1:0]           sync2_q;
    logic [NumCh-1:0]           db_q;
    logic [NumCh-1:0]           db_d;
    logic [NumCh-1:0][CntW-1:0] cnt_q;
    logic [NumCh-1:0][CntW-1:0] cnt_d;
    logic                       key_prev_q;
    logic                       run_s;
    logic                       press;

    state_e                     state_q;
    state_e                     state_d;
    logic                       first_run_q;
    logic                       bp_take;

    logic                       cpu_en_q;
    logic                       cpu_en_d;
    logic                       halted_q;
    logic                       halted_d;
    logic                       bp_hit_q;
    logic                       bp_hit_d;
    logic [15:0]                step_count_q;
    logic [15:0]                step_count_d;

    assign raw_in = {step_key_n, run_sw};

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sync1_q <= InIdle;
            sync2_q <= InIdle;
        end else begin
            sync1_q <= raw_in;
            sync2_q <= sync1_q;
        end
    end

    // Count consecutive samples that disagree with the accepted level; any agreeing sample
    // restarts the count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        for (int i = 0; i < NumCh; i++) begin
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            db_q       <= InIdle;
            cnt_q      <= '0;
            key_prev_q <= 1'b1;
        end else begin
            db_q       <= db_d;
            cnt_q      <= cnt_d;
            key_prev_q <= db_q[ChKey];
        end
    end

    assign run_s = db_q[ChRun];
    assign press = key_prev_q & ~db_q[ChKey];

    // The compare is masked on the first RUN cycle so a run may start at the breakpoint.
    assign bp_take = bp_en & (instr_if == bp_addr) & ~first_run_q;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q     <= StHalt;
            first_run_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            first_run_q <= (state_q != StRun);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StHalt: begin
                if (run_s) begin
                    state_d = StRun;
                end else if (press) begin
                    state_d = StStep;
                end
            end
            StStep: begin
                state_d = StHalt;
            end
            StRun: begin
                if (!run_s) begin
                    state_d = StHalt;
                end else if (bp_take) begin
                    state_d = StBreak;
                end
            end
            StBreak: begin
                if (!run_s) begin
                    state_d = StHalt;
                end else if (press) begin
                    state_d = StStep;
                end
            end
            default: begin
                state_d = StHalt;
            end
        endcase
    end

    always_comb begin
        cpu_en_d = (state_d == StStep) || (state_d == StRun);
        halted_d = ~cpu_en_d;

        bp_hit_d = bp_hit_q;
        if ((state_d == StBreak) && (state_q != StBreak)) begin
            bp_hit_d = 1'b1;
        end else if (cpu_en_d && (state_d != state_q)) begin
            bp_hit_d = 1'b0;
        end

        step_count_d = step_count_q;
        if (cpu_en_q && (step_count_q != 16'hFFFF)) begin
            step_count_d = step_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            cpu_en_q     <= 1'b0;
            halted_q     <= 1'b1;
            bp_hit_q     <= 1'b0;
            step_count_q <= '0;
        end else begin
            cpu_en_q     <= cpu_en_d;
            halted_q     <= halted_d;
            bp_hit_q     <= bp_hit_d;
            step_count_q <= step_count_d;
        end
    end

    assign cpu_en     = cpu_en_q;
    assign halted     = halted_q;
    assign bp_hit     = bp_hit_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Self-checking bench for debug_step_ctrl with a short debounce window.
module tb_debug_step_ctrl;

    localparam int unsigned Db = 4;
    localparam int unsigned Aw = 32;

    logic          clk_clk = 1'b0;
    logic          reset_reset_n = 1'b1;
    logic          run_sw = 1'b0;
    logic          step_key_n = 1'b1;
    logic          bp_en = 1'b0;
    logic [Aw-1:0] bp_addr = '0;
    logic [Aw-1:0] instr_if = '0;
    logic          cpu_en;
    logic          halted;
    logic          bp_hit;
    logic [15:0]   step_count;

    debug_step_ctrl #(
        .DEBOUNCE_CYCLES(Db),
        .ADDR_W         (Aw)
    ) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .run_sw       (run_sw),
        .step_key_n   (step_key_n),
        .bp_en        (bp_en),
        .bp_addr      (bp_addr),
        .instr_if     (instr_if),
        .cpu_en       (cpu_en),
        .halted       (halted),
        .bp_hit       (bp_hit),
        .step_count   (step_count)
    );

    always #5 clk_clk = ~clk_clk;

    typedef struct {
        int unsigned low;
        int unsigned pulses;
    } key_vec_t;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned model_cnt = 0;
    bit          prev_en = 1'b0;
    sb_t         sb_q[$];
    key_vec_t    kv[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic [31:0] exp);
        sb_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] act);
        sb_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_underflow: got %0h, expected nothing", act);
        end else begin
            e = sb_q.pop_front();
            check(e.name, act, e.exp);
        end
    endtask

    // One clock, sampled 1 ns after the edge; the enable model tracks the saturating counter.
    task automatic tick();
        @(posedge clk_clk);
        #1;
        if (prev_en && model_cnt < 32'hFFFF) model_cnt++;
        prev_en = cpu_en;
    endtask

    task automatic wait_en(input string name, input logic level, input int unsigned bound,
                           output int unsigned lat);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (cpu_en !== level && lat < bound);
        check(name, cpu_en, level);
    endtask

    initial begin
        int unsigned lat;
        int unsigned exp_total;
        int unsigned cnt;
        bit          dropped;

        kv[0] = '{low: 1,  pulses: 0};
        kv[1] = '{low: 3,  pulses: 0};
        kv[2] = '{low: 4,  pulses: 1};
        kv[3] = '{low: 20, pulses: 1};
        kv[4] = '{low: 2,  pulses: 0};
        kv[5] = '{low: 6,  pulses: 1};

        #1 reset_reset_n = 1'b0;
        #1;
        check("rst_cpu_en", cpu_en, 0);
        check("rst_halted", halted, 1);
        check("rst_bp_hit", bp_hit, 0);
        check("rst_count", step_count, 0);
        tick();
        tick();
        reset_reset_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Key press table: glitches shorter than the debounce window give nothing.
        exp_total = 0;
        for (int v = 0; v < 6; v++) begin
            int unsigned pulses;
            int unsigned first;
            pulses = 0;
            first  = 0;
            sb_push($sformatf("key_pulses_%0d", v), kv[v].pulses);
            sb_push($sformatf("key_halted_%0d", v), 1);
            step_key_n = 1'b0;
            for (int c = 0; c < int'(kv[v].low) + 16; c++) begin
                if (c == int'(kv[v].low)) step_key_n = 1'b1;
                tick();
                if (cpu_en) begin
                    pulses++;
                    if (first == 0) first = c + 1;
                end
            end
            sb_pop(pulses);
            sb_pop(halted);
            if (kv[v].pulses != 0) begin
                check($sformatf("key_latency_%0d_is_%0d", v, first),
                      (first >= 6 && first <= 7), 1);
            end
            exp_total += kv[v].pulses;
        end
        check("key_count", step_count, exp_total);

        // Free run with a matching address but breakpoints disabled; presses are ignored.
        bp_en    = 1'b0;
        bp_addr  = 32'h40;
        instr_if = 32'h40;
        run_sw   = 1'b1;
        wait_en("run_start", 1, 20, lat);
        check($sformatf("run_latency_%0d", lat), (lat >= 6 && lat <= 7), 1);
        dropped = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (i == 100) step_key_n = 1'b0;
            if (i == 110) step_key_n = 1'b1;
            tick();
            if (!cpu_en) dropped = 1'b1;
        end
        check("run_no_drop", dropped, 0);
        run_sw = 1'b0;
        wait_en("run_stop", 0, 20, lat);
        check("run_stop_halted", halted, 1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_en) cnt++;
        end
        check("no_queued_press", cnt, 0);
        check("run_count", step_count, model_cnt);
        check("run_count_min", (model_cnt >= exp_total + 301), 1);

        // Address ramp into the breakpoint.
        bp_en    = 1'b1;
        instr_if = 32'h0;
        run_sw   = 1'b1;
        wait_en("bp_run_start", 1, 20, lat);
        for (int a = 4; a <= 32'h40; a += 4) begin
            instr_if = a;
            sb_push($sformatf("bp_ramp_en_%0h", a), (a == 32'h40) ? 0 : 1);
            tick();
            sb_pop(cpu_en);
        end
        check("bp_halted", halted, 1);
        check("bp_hit_set", bp_hit, 1);
        for (int i = 0; i < 5; i++) tick();
        check("bp_break_hold", cpu_en, 0);

        // BREAK -> HALT keeps the flag; re-entering RUN at the breakpoint masks one cycle.
        run_sw = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        check("halt_keeps_hit", bp_hit, 1);
        check("halt_cpu_en", cpu_en, 0);
        run_sw = 1'b1;
        wait_en("rerun_start", 1, 20, lat);
        check("rerun_clears_hit", bp_hit, 0);
        tick();
        check("rerun_masked_first", cpu_en, 1);
        tick();
        check("rerun_break_en", cpu_en, 0);
        check("rerun_break_hit", bp_hit, 1);

        // Step out of BREAK, then HALT -> RUN from the breakpoint address.
        step_key_n = 1'b0;
        wait_en("brk_step", 1, 20, lat);
        check("brk_step_hit_clr", bp_hit, 0);
        check("brk_step_halted", halted, 0);
        step_key_n = 1'b1;
        tick();
        check("step_one_cycle", cpu_en, 0);
        check("step_then_halt_hit", bp_hit, 0);
        tick();
        check("resume_run", cpu_en, 1);
        tick();
        check("resume_no_rebreak", cpu_en, 1);
        instr_if = 32'h44;
        for (int i = 0; i < 5; i++) tick();
        check("resume_running", cpu_en, 1);

        // Asynchronous reset in the middle of a cycle.
        #2;
        reset_reset_n = 1'b0;
        run_sw        = 1'b0;
        model_cnt     = 0;
        prev_en       = 1'b0;
        #1;
        check("arst_cpu_en", cpu_en, 0);
        check("arst_halted", halted, 1);
        check("arst_bp_hit", bp_hit, 0);
        check("arst_count", step_count, 0);
        tick();
        tick();
        reset_reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cpu_en) cnt++;
        end
        check("post_rst_idle", cnt, 0);
        check("post_rst_halted", halted, 1);

        // Saturation of the enabled-cycle counter.
        bp_en  = 1'b0;
        run_sw = 1'b1;
        wait_en("sat_run", 1, 20, lat);
        for (int i = 0; i < 65540; i++) tick();
        check("sat_value", step_count, 16'hFFFF);
        for (int i = 0; i < 5; i++) tick();
        check("sat_hold", step_count, 16'hFFFF);
        check("sat_model", step_count, model_cnt);
        check("sat_still_run", cpu_en, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
